// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: producer side, consumer side and flush.
// The slave modport is the buffer's view; master is the surrounding pipeline's view.
interface pipe_skid_reg_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occupancy
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output occupancy
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready skid buffer with registered in_ready and synchronous flush.
// out_data always comes from the main register; the skid register only absorbs one stalled beat.
module pipe_skid_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    pipe_skid_reg_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             pop;

    always_comb begin
        accept  = bus.in_valid & in_ready_q;
        pop     = (state_q != EMPTY) & bus.out_ready;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = bus.in_data;
                end
            end
            ONE: begin
                case ({accept, pop})
                    2'b10: begin
                        state_d = FULL;
                        skid_d  = bus.in_data;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: main_d  = bus.in_data;
                    default: ;
                endcase
            end
            FULL: begin
                // in_ready is low here, so the only movement is skid -> main on a pop.
                if (pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (bus.flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end

        // Registered from next state, so out_ready never reaches in_ready combinationally.
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        bus.in_ready  = in_ready_q;
        bus.out_valid = (state_q != EMPTY);
        bus.out_data  = main_q;
        case (state_q)
            ONE:     bus.occupancy = 2'd1;
            FULL:    bus.occupancy = 2'd2;
            default: bus.occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized and directed bench for pipe_skid_reg against a queue-based FIFO reference model.
// The model keeps beats in a queue of capacity two; in_ready follows the queue fill.
module tb_pipe_skid_reg;

    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_skid_reg_if #(.WIDTH(WIDTH)) bus ();

    pipe_skid_reg #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [WIDTH-1:0] m_q[$];
    bit               m_ready  = 1'b0;
    bit               m_zero   = 1'b1;
    bit               m_live   = 1'b0;
    bit               last_acc = 1'b0;
    bit               pend_v   = 1'b0;
    logic [WIDTH-1:0] pend_d   = '0;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: compare at negedge, advance model at posedge, return at posedge+1.
    task automatic step();
        bit               acc;
        bit               pp;
        logic [WIDTH-1:0] din;
        @(negedge clk);
        check("out_valid", {63'd0, bus.out_valid}, {63'd0, m_q.size() != 0});
        check("occupancy", {62'd0, bus.occupancy}, 64'(m_q.size()));
        check("in_ready", {63'd0, bus.in_ready}, {63'd0, m_ready});
        if (m_q.size() != 0)
            check("out_data", {32'd0, bus.out_data}, {32'd0, m_q[0]});
        else if (m_zero)
            check("out_data_zero", {32'd0, bus.out_data}, 64'd0);
        if (m_live)
            check("ready_occ", {63'd0, bus.in_ready}, {63'd0, bus.occupancy != 2'd2});
        if (prev_stall)
            check("stall_data", {32'd0, bus.out_data}, {32'd0, prev_data});
        if (pend_v)
            assert (bus.in_valid && bus.in_data == pend_d)
                else $error("producer hold rule violated by stimulus");

        acc        = bus.in_valid && m_ready;
        pp         = (m_q.size() != 0) && bus.out_ready;
        din        = bus.in_data;
        prev_stall = (m_q.size() != 0) && !bus.out_ready && !rst && !bus.flush;
        prev_data  = (m_q.size() != 0) ? m_q[0] : '0;
        pend_v     = bus.in_valid && !acc && !rst && !bus.flush;
        pend_d     = din;

        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_ready = 1'b0;
            m_zero  = 1'b1;
            m_live  = 1'b0;
        end else if (bus.flush) begin
            m_q.delete();
            m_ready = 1'b1;
            m_zero  = 1'b1;
            m_live  = 1'b1;
        end else begin
            if (pp) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(din);
                m_zero = 1'b0;
            end
            m_ready = (m_q.size() != 2);
            m_live  = 1'b1;
        end
        last_acc = acc && !rst && !bus.flush;
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEAD;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with a beat offered
        repeat (2) step();
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_out_data", {32'd0, bus.out_data}, 64'd0);
        check("rst_occupancy", {62'd0, bus.occupancy}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check("rst_ready_rise", {63'd0, bus.in_ready}, 64'd1);

        // Back-to-back stream
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(i);
            step();
            check("stream_acc", {63'd0, last_acc}, 64'd1);
        end
        drain();

        // Backpressure fills both entries and stalls the third beat
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA; step();
        bus.in_data   = 32'hB; step();
        bus.in_data   = 32'hC; step();
        check("bp_occ", {62'd0, bus.occupancy}, 64'd2);
        check("bp_ready", {63'd0, bus.in_ready}, 64'd0);
        check("bp_head", {32'd0, bus.out_data}, 64'hA);
        step();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10 && !last_acc; k++) step();
        check("bp_c_accepted", {63'd0, last_acc}, 64'd1);
        drain();

        // Accept and pop together while holding one beat
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h11;
        step();
        bus.out_ready = 1'b1;
        bus.in_data   = 32'h22;
        step();
        check("ap_occ", {62'd0, bus.occupancy}, 64'd1);
        check("ap_data", {32'd0, bus.out_data}, 64'h22);
        drain();

        // Flush while full with a beat offered
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h44; step();
        bus.in_data   = 32'h55; step();
        bus.flush     = 1'b1;
        bus.in_data   = 32'h33;
        step();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        check("fl_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("fl_occ", {62'd0, bus.occupancy}, 64'd0);
        check("fl_out_data", {32'd0, bus.out_data}, 64'd0);
        check("fl_in_ready", {63'd0, bus.in_ready}, 64'd1);
        drain();

        // Random traffic with occasional flush and reset
        for (int c = 0; c < 10000; c++) begin
            rst       = ($urandom_range(0, 999) == 0);
            bus.flush = ($urandom_range(0, 63) == 0);
            case ((c / 1000) % 3)
                0:       bus.out_ready = ($urandom_range(0, 3) != 0);
                1:       bus.out_ready = ($urandom_range(0, 3) == 0);
                default: bus.out_ready = $urandom_range(0, 1);
            endcase
            if (!pend_v) begin
                bus.in_valid = $urandom_range(0, 1);
                bus.in_data  = $urandom;
            end
            step();
        end
        rst       = 1'b0;
        bus.flush = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
